l1_header_fifo_param: RTL and testbench
=======================================

Name: l1_header_fifo_param

Overview:
- Parametrised L1 trigger-header buffer on `bx_clk`; a successor to the fixed 256-deep header FIFO.
- On each L1 accept it captures event ID, spill number, time-in-spill and BX ID into a FIFO.
- It presents the head entry to the event builder, which pops it with `advance`.
- Adds over the fixed version: true full/empty, no occupancy wrap, overflow drop accounting, single-clock time-in-spill prescaler.

Parameters:
- DEPTH_LOG2, 8, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2).
- EVTID_W, 32, event ID counter width.
- SPILL_W, 12, spill counter width.
- BXID_W, 12, BX ID width.
- TIS_W, 32, time-in-spill counter width.
- TIS_DIV, 25, `bx_clk` cycles per time-in-spill tick (>=1).
- THROTTLE_LEVEL, 2**DEPTH_LOG2-4, occupancy at/above which `throttle` asserts (only with L1_HDR_THROTTLE_EN).

Ports:
- bx_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- l1a  in  1  L1 accept strobe, one cycle per trigger
- newspill  in  1  spill-start strobe
- bxid  in  BXID_W  current BX ID, sampled with l1a
- advance  in  1  pop head entry; honoured only while tag_valid=1
- clr_overflow  in  1  clears overflow flag and drop_count
- occupancy  out  DEPTH_LOG2+1  entries stored
- full  out  1  occupancy == DEPTH
- tag_valid  out  1  tag_* hold a valid head entry
- tag_evtid  out  EVTID_W  head event ID
- tag_timeinspill  out  TIS_W  head time-in-spill
- tag_spill  out  SPILL_W  head spill number
- tag_bxid  out  BXID_W  head BX ID
- evtid  out  EVTID_W  live event counter
- spill  out  SPILL_W  live spill counter
- overflow  out  1  sticky: an l1a was dropped
- drop_count  out  16  dropped-l1a count, saturating at 0xFFFF
- throttle  out  1  almost-full (feature only; else tied 0)

Behaviour:
- Reset (async assert, sync release): wptr, rptr, occupancy, evtid, spill, timeinspill, prescaler, drop_count, tag_* all clear to 0. tag_valid, overflow, throttle, full go to 0. Memory contents are undefined.
- Write: an l1a at edge E is accepted iff occupancy != DEPTH before E. This check ignores a same-cycle advance.
  - Accepted: mem[wptr] <= {evtid, timeinspill, spill, bxid}, using register values before edge E. wptr increments with natural wrap at DEPTH.
  - Dropped: nothing is written. overflow <= 1; drop_count increments, saturating.
- evtid increments on every l1a, accepted or dropped, so downstream sees gaps. It wraps at 2**EVTID_W.
- Spill: newspill increments spill (wrap at 2**SPILL_W). It clears timeinspill and the prescaler to 0 at the same edge.
  - l1a coincident with newspill captures the old spill and old timeinspill.
- Time-in-spill: the prescaler counts 0..TIS_DIV-1. On reaching TIS_DIV-1, timeinspill increments (wrapping) and the prescaler returns to 0.
- Read pipeline: every edge, tag_* <= mem[rptr] (pre-edge rptr).
  - Pop accepted = advance && tag_valid. A pop increments rptr, and tag_valid <= 0 at that edge (stale tags).
  - Otherwise tag_valid <= (occupancy != 0).
  - l1a accepted at edge E into an empty FIFO gives tag_valid=1 after edge E+1.
  - Maximum pop rate is one per two cycles.
  - advance while tag_valid=0 is ignored.
- occupancy: +1 on accepted write, -1 on accepted pop, unchanged when both or neither occur. Never wraps; range 0..DEPTH.
- clr_overflow clears overflow and drop_count. A drop in the same cycle wins: overflow=1, drop_count=1.
- full is combinational from occupancy.

Optional Feature:
- Macro L1_HDR_THROTTLE_EN.
- Defined: throttle is registered, = 1 when next occupancy >= THROTTLE_LEVEL, else 0. Reset 0.
- Undefined: throttle tied 0, and the THROTTLE_LEVEL compare logic is absent.

Test Plan:
- Reset, then 3 l1a with bxid 0x010, 0x020, 0x030 → occupancy=3; tag_valid=1 two edges after the first l1a; tag_evtid=0, tag_bxid=0x010.
- Pop all three with advance held high → heads evtid 0,1,2 each presented with tag_valid; tag_valid low one cycle between pops; occupancy returns to 0; extra advance ignored.
- DEPTH_LOG2=2: 6 l1a with no pops → occupancy=4, full=1; 2 drops; overflow=1, drop_count=2, evtid=6; stored evtids 0..3. Then clr_overflow → overflow=0, drop_count=0.
- TIS_DIV=4: newspill, wait 17 cycles, l1a → tag_timeinspill=4, tag_spill=1. l1a coincident with a second newspill → captures spill=1 and old timeinspill.
- 300 writes/pops interleaved, DEPTH_LOG2=8 → pointers wrap; data order intact; occupancy never exceeds 256.
- L1_HDR_THROTTLE_EN, DEPTH_LOG2=4, THROTTLE_LEVEL=12: fill to 12 → throttle=1 at the 12th write edge; one pop → throttle=0. Assert reset_n low mid-fill → all outputs 0 immediately.

Source files
------------

// File: rtl/l1_header_fifo_param.sv
// l1_header_fifo_param: parametrised L1 trigger-header FIFO with overflow drop accounting and time-in-spill prescaler.
// Optional almost-full throttle output is built only when L1_HDR_THROTTLE_EN is defined.
module l1_header_fifo_param #(
  parameter int DEPTH_LOG2     = 8,
  parameter int EVTID_W        = 32,
  parameter int SPILL_W        = 12,
  parameter int BXID_W         = 12,
  parameter int TIS_W          = 32,
  parameter int TIS_DIV        = 25,
  parameter int THROTTLE_LEVEL = 2**DEPTH_LOG2-4
) (
  input  logic                  bx_clk,
  input  logic                  reset_n,
  input  logic                  l1a,
  input  logic                  newspill,
  input  logic [BXID_W-1:0]     bxid,
  input  logic                  advance,
  input  logic                  clr_overflow,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  full,
  output logic                  tag_valid,
  output logic [EVTID_W-1:0]    tag_evtid,
  output logic [TIS_W-1:0]      tag_timeinspill,
  output logic [SPILL_W-1:0]    tag_spill,
  output logic [BXID_W-1:0]     tag_bxid,
  output logic [EVTID_W-1:0]    evtid,
  output logic [SPILL_W-1:0]    spill,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic                  throttle
);
  localparam int ENTRY_W = EVTID_W + TIS_W + SPILL_W + BXID_W;
  localparam int PS_W = TIS_DIV > 1 ? $clog2(TIS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TIS_DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (TIS_DIV < 1 || THROTTLE_LEVEL > 2**DEPTH_LOG2) begin : g_bad_param
    $error("l1_header_fifo_param: TIS_DIV must be >= 1 and THROTTLE_LEVEL <= depth");
  end

  logic [ENTRY_W-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [TIS_W-1:0]      timeinspill;
  logic [PS_W-1:0]       ps;
  logic                  wr, pop;
  logic [DEPTH_LOG2:0]   occ_next;

  assign full = occupancy == FULL_OCC;

  always_comb begin
    wr = l1a && !full;
    pop = advance && tag_valid;
    occ_next = occupancy + {{DEPTH_LOG2{1'b0}}, wr} - {{DEPTH_LOG2{1'b0}}, pop};
  end

  always_ff @(posedge bx_clk or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      occupancy <= '0;
      evtid <= '0;
      spill <= '0;
      timeinspill <= '0;
      ps <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      wptr <= wr ? wptr + DEPTH_LOG2'(1) : wptr;
      rptr <= pop ? rptr + DEPTH_LOG2'(1) : rptr;
      occupancy <= occ_next;
      evtid <= l1a ? evtid + EVTID_W'(1) : evtid;
      spill <= newspill ? spill + SPILL_W'(1) : spill;
      ps <= (newspill || ps == PS_MAX) ? '0 : ps + PS_W'(1);
      timeinspill <= newspill ? '0 : ps == PS_MAX ? timeinspill + TIS_W'(1) : timeinspill;
      // a drop in the same cycle as clr_overflow restarts the count at one
      if (l1a && full) begin
        overflow <= 1'b1;
        drop_count <= clr_overflow ? 16'd1 : drop_count == 16'hFFFF ? drop_count : drop_count + 16'd1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
        drop_count <= '0;
      end
    end

  always_ff @(posedge bx_clk)
    if (wr) mem[wptr] <= {evtid, timeinspill, spill, bxid};

  always_ff @(posedge bx_clk or negedge reset_n)
    if (!reset_n) begin
      {tag_evtid, tag_timeinspill, tag_spill, tag_bxid} <= '0;
      tag_valid <= 1'b0;
    end else begin
      {tag_evtid, tag_timeinspill, tag_spill, tag_bxid} <= mem[rptr];
      tag_valid <= !pop && occupancy != '0;
    end

`ifdef L1_HDR_THROTTLE_EN
  always_ff @(posedge bx_clk or negedge reset_n)
    if (!reset_n) throttle <= 1'b0;
    else throttle <= int'(occ_next) >= THROTTLE_LEVEL;
`else
  assign throttle = 1'b0;
`endif
endmodule

// File: tb/tb_l1_header_fifo_param.sv
// tb_l1_header_fifo_param: directed checks of the L1 header FIFO on a 256-deep (TIS_DIV=4) and a 4-deep instance.
module tb_l1_header_fifo_param;
  logic bx_clk = 1'b0, reset_n = 1'b0, l1a = 1'b0, newspill = 1'b0, advance = 1'b0, clr_overflow = 1'b0;
  logic [11:0] bxid = '0;
  int tests = 0, fails = 0;

  logic [8:0]  a_occupancy;
  logic        a_full, a_tag_valid, a_overflow, a_throttle;
  logic [31:0] a_tag_evtid, a_tag_tis, a_evtid;
  logic [11:0] a_tag_spill, a_tag_bxid, a_spill;
  logic [15:0] a_drop_count;
  logic [2:0]  b_occupancy;
  logic        b_full, b_tag_valid, b_overflow, b_throttle;
  logic [31:0] b_tag_evtid, b_tag_tis, b_evtid;
  logic [11:0] b_tag_spill, b_tag_bxid, b_spill;
  logic [15:0] b_drop_count;

  always #5 bx_clk = ~bx_clk;

  l1_header_fifo_param #(.DEPTH_LOG2(8), .TIS_DIV(4)) u_a (
    .bx_clk(bx_clk), .reset_n(reset_n), .l1a(l1a), .newspill(newspill), .bxid(bxid),
    .advance(advance), .clr_overflow(clr_overflow), .occupancy(a_occupancy), .full(a_full),
    .tag_valid(a_tag_valid), .tag_evtid(a_tag_evtid), .tag_timeinspill(a_tag_tis),
    .tag_spill(a_tag_spill), .tag_bxid(a_tag_bxid), .evtid(a_evtid), .spill(a_spill),
    .overflow(a_overflow), .drop_count(a_drop_count), .throttle(a_throttle));

  l1_header_fifo_param #(.DEPTH_LOG2(2), .THROTTLE_LEVEL(3)) u_b (
    .bx_clk(bx_clk), .reset_n(reset_n), .l1a(l1a), .newspill(newspill), .bxid(bxid),
    .advance(advance), .clr_overflow(clr_overflow), .occupancy(b_occupancy), .full(b_full),
    .tag_valid(b_tag_valid), .tag_evtid(b_tag_evtid), .tag_timeinspill(b_tag_tis),
    .tag_spill(b_tag_spill), .tag_bxid(b_tag_bxid), .evtid(b_evtid), .spill(b_spill),
    .overflow(b_overflow), .drop_count(b_drop_count), .throttle(b_throttle));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bx_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    {l1a, newspill, advance, clr_overflow} = '0;
    bxid = '0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    tests++; if ({a_occupancy, a_tag_valid, a_full, a_evtid, a_spill} !== '0) begin fails++; $display("FAIL reset_a_state: occ=%0d valid=%0b full=%0b evtid=%0d spill=%0d, want all 0", a_occupancy, a_tag_valid, a_full, a_evtid, a_spill); end
    tests++; if ({a_overflow, a_drop_count, a_throttle, a_tag_evtid, a_tag_bxid} !== '0) begin fails++; $display("FAIL reset_a_flags: ovf=%0b drops=%0d thr=%0b tag_evtid=%0h tag_bxid=%0h, want 0", a_overflow, a_drop_count, a_throttle, a_tag_evtid, a_tag_bxid); end
    tests++; if ({b_occupancy, b_full, b_overflow} !== '0) begin fails++; $display("FAIL reset_b: occ=%0d full=%0b ovf=%0b, want 0", b_occupancy, b_full, b_overflow); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_write();
    do_reset();
    l1a = 1'b1; bxid = 12'h010;
    tick(1);
    tests++; if ({a_occupancy, a_tag_valid} !== {9'd1, 1'b0}) begin fails++; $display("FAIL write1: occ=%0d valid=%0b, want 1/0", a_occupancy, a_tag_valid); end
    bxid = 12'h020;
    tick(1);
    tests++; if ({a_tag_valid, a_tag_evtid, a_tag_bxid} !== {1'b1, 32'd0, 12'h010}) begin fails++; $display("FAIL head_after_2_edges: valid=%0b evtid=%0d bxid=%0h, want 1/0/010", a_tag_valid, a_tag_evtid, a_tag_bxid); end
    bxid = 12'h030;
    tick(1);
    l1a = 1'b0;
    tests++; if ({a_occupancy, a_evtid} !== {9'd3, 32'd3}) begin fails++; $display("FAIL write3: occ=%0d evtid=%0d, want 3/3", a_occupancy, a_evtid); end
  endtask

  task automatic test_pop();
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({a_tag_valid, a_tag_evtid, a_tag_bxid} !== {1'b1, 32'(i), 12'(16 * (i + 1))}) begin fails++; $display("FAIL pop_head%0d: valid=%0b evtid=%0d bxid=%0h, want 1/%0d/%0h", i, a_tag_valid, a_tag_evtid, a_tag_bxid, i, 16 * (i + 1)); end
      tick(1);
      tests++; if ({a_tag_valid, a_occupancy} !== {1'b0, 9'(2 - i)}) begin fails++; $display("FAIL pop_gap%0d: valid=%0b occ=%0d, want 0/%0d", i, a_tag_valid, a_occupancy, 2 - i); end
      tick(1);
    end
    tick(2);
    advance = 1'b0;
    tests++; if ({a_tag_valid, a_occupancy} !== {1'b0, 9'd0}) begin fails++; $display("FAIL pop_empty_ignored: valid=%0b occ=%0d, want 0/0", a_tag_valid, a_occupancy); end
  endtask

  task automatic test_overflow();
    do_reset();
    l1a = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      bxid = 12'(j);
      tick(1);
      tests++; if ({b_occupancy, b_full, b_overflow} !== {3'(j < 4 ? j : 4), j >= 4, j >= 5}) begin fails++; $display("FAIL fill%0d: occ=%0d full=%0b ovf=%0b, want %0d/%0b/%0b", j, b_occupancy, b_full, b_overflow, j < 4 ? j : 4, j >= 4, j >= 5); end
    end
    l1a = 1'b0;
    tests++; if ({b_drop_count, b_evtid} !== {16'd2, 32'd6}) begin fails++; $display("FAIL drops: drop_count=%0d evtid=%0d, want 2/6", b_drop_count, b_evtid); end
    for (int i = 0; i < 4; i++) begin
      tests++; if ({b_tag_valid, b_tag_evtid} !== {1'b1, 32'(i)}) begin fails++; $display("FAIL stored%0d: valid=%0b evtid=%0d, want 1/%0d", i, b_tag_valid, b_tag_evtid, i); end
      advance = 1'b1; tick(1);
      advance = 1'b0; tick(1);
    end
    tests++; if ({b_occupancy, b_full} !== {3'd0, 1'b0}) begin fails++; $display("FAIL drained: occ=%0d full=%0b, want 0/0", b_occupancy, b_full); end
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    tests++; if ({b_overflow, b_drop_count} !== {1'b0, 16'd0}) begin fails++; $display("FAIL clr: ovf=%0b drops=%0d, want 0/0", b_overflow, b_drop_count); end
    l1a = 1'b1; tick(4);
    advance = 1'b1; tick(1); advance = 1'b0;
    tests++; if ({b_occupancy, b_overflow, b_drop_count} !== {3'd3, 1'b1, 16'd1}) begin fails++; $display("FAIL full_pop_drop: occ=%0d ovf=%0b drops=%0d, want 3/1/1", b_occupancy, b_overflow, b_drop_count); end
    tick(1);
    clr_overflow = 1'b1; tick(1);
    {l1a, clr_overflow} = '0;
    tests++; if ({b_overflow, b_drop_count} !== {1'b1, 16'd1}) begin fails++; $display("FAIL clr_vs_drop: ovf=%0b drops=%0d, want 1/1", b_overflow, b_drop_count); end
  endtask

  task automatic test_spill();
    do_reset();
    newspill = 1'b1; tick(1); newspill = 1'b0;
    tests++; if (a_spill !== 12'd1) begin fails++; $display("FAIL spill_inc: spill=%0d, want 1", a_spill); end
    tick(17);
    l1a = 1'b1; bxid = 12'h055; tick(1); l1a = 1'b0;
    tick(1);
    tests++; if ({a_tag_valid, a_tag_tis, a_tag_spill} !== {1'b1, 32'd4, 12'd1}) begin fails++; $display("FAIL tis_capture: valid=%0b tis=%0d spill=%0d, want 1/4/1", a_tag_valid, a_tag_tis, a_tag_spill); end
    {l1a, newspill} = 2'b11; tick(1); {l1a, newspill} = 2'b00;
    tests++; if ({a_spill, a_evtid} !== {12'd2, 32'd2}) begin fails++; $display("FAIL spill2: spill=%0d evtid=%0d, want 2/2", a_spill, a_evtid); end
    advance = 1'b1; tick(1); advance = 1'b0; tick(1);
    tests++; if ({a_tag_valid, a_tag_evtid, a_tag_tis, a_tag_spill} !== {1'b1, 32'd1, 32'd4, 12'd1}) begin fails++; $display("FAIL coincident: valid=%0b evtid=%0d tis=%0d spill=%0d, want 1/1/4/1", a_tag_valid, a_tag_evtid, a_tag_tis, a_tag_spill); end
    tick(1);
    l1a = 1'b1; tick(2); l1a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advance = 1'b1; tick(1); advance = 1'b0; tick(1);
      tests++; if ({a_tag_evtid, a_tag_tis, a_tag_spill} !== {32'(i + 2), 32'(i), 12'd2}) begin fails++; $display("FAIL tis_restart%0d: evtid=%0d tis=%0d spill=%0d, want %0d/%0d/2", i, a_tag_evtid, a_tag_tis, a_tag_spill, i + 2, i); end
    end
  endtask

  task automatic test_wrap();
    int wr_n = 0, rd_n = 0, cyc = 0;
    logic pop_now;
    do_reset();
    advance = 1'b1;
    while (rd_n < 300 && cyc < 2000) begin
      l1a = wr_n < 300;
      bxid = 12'(wr_n);
      pop_now = a_tag_valid;
      if (pop_now) begin
        tests++; if ({a_tag_evtid, a_tag_bxid} !== {32'(rd_n), 12'(rd_n)}) begin fails++; $display("FAIL wrap_order: evtid=%0d bxid=%0h, want %0d/%0h", a_tag_evtid, a_tag_bxid, rd_n, 12'(rd_n)); end
      end
      tick(1);
      if (l1a) wr_n++;
      if (pop_now) rd_n++;
      tests++; if (a_occupancy !== 9'(wr_n - rd_n)) begin fails++; $display("FAIL wrap_occ: occ=%0d, want %0d", a_occupancy, wr_n - rd_n); end
      cyc++;
    end
    {l1a, advance} = '0;
    tests++; if (rd_n != 300) begin fails++; $display("FAIL wrap_timeout: popped %0d, want 300", rd_n); end
  endtask

  task automatic test_throttle_async_reset();
    logic exp_thr;
    do_reset();
    l1a = 1'b1; bxid = 12'h7AB;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
`ifdef L1_HDR_THROTTLE_EN
      exp_thr = j >= 3;
`else
      exp_thr = 1'b0;
`endif
      tests++; if (b_throttle !== exp_thr) begin fails++; $display("FAIL throttle%0d: throttle=%0b, want %0b", j, b_throttle, exp_thr); end
    end
    tests++; if ({a_evtid, b_overflow} !== {32'd5, 1'b1}) begin fails++; $display("FAIL prefill: evtid=%0d ovf=%0b, want 5/1", a_evtid, b_overflow); end
    #3 reset_n = 1'b0;
    #1;
    tests++; if ({a_occupancy, a_evtid, a_tag_valid, a_tag_bxid, a_throttle} !== '0) begin fails++; $display("FAIL async_a: occ=%0d evtid=%0d valid=%0b bxid=%0h thr=%0b, want 0", a_occupancy, a_evtid, a_tag_valid, a_tag_bxid, a_throttle); end
    tests++; if ({b_full, b_overflow, b_drop_count, b_throttle, b_occupancy} !== '0) begin fails++; $display("FAIL async_b: full=%0b ovf=%0b drops=%0d thr=%0b occ=%0d, want 0", b_full, b_overflow, b_drop_count, b_throttle, b_occupancy); end
    l1a = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_pop();
    test_overflow();
    test_spill();
    test_wrap();
    test_throttle_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
